// File: rtl/alu_issue.sv
// Issue/writeback stage feeding a combinational ALU: owns an 8-entry register file,
// issues one command at a time and writes ALU results back two cycles after acceptance.
module alu_issue #(
  parameter int REG_WIDTH   = 8,
  parameter int OPSEL_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OPSEL_WIDTH-1:0] cmd_opsel,
  input  logic [2:0]             cmd_ra,
  input  logic [2:0]             cmd_rb,
  input  logic [2:0]             cmd_rd,
  input  logic                   cmd_wr_h,
  input  logic                   ld_en,
  input  logic [2:0]             ld_addr,
  input  logic [REG_WIDTH-1:0]   ld_data,
  input  logic [2:0]             obs_addr,
  output logic [REG_WIDTH-1:0]   obs_data,
  output logic [REG_WIDTH-1:0]   op_a,
  output logic [REG_WIDTH-1:0]   op_b,
  output logic [OPSEL_WIDTH-1:0] alu_opsel,
  input  logic [REG_WIDTH-1:0]   alu_result_l,
  input  logic [REG_WIDTH-1:0]   alu_result_h,
  input  logic                   ovf_flag,
  input  logic                   cf_flag,
  input  logic                   zero_flag_l,
  input  logic                   zero_flag_h,
  output logic [3:0]             flags,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [REG_WIDTH-1:0] rf [8];
  logic [2:0]           rd_q;
  logic [2:0]           rd_h;
  logic                 wr_h_q;
  logic                 accept;
  logic                 wb;

  assign accept   = cmd_valid && cmd_ready;
  assign wb       = (state == WB);
  // 3-bit add wraps rd=7 onto index 0 for the high result
  assign rd_h     = rd_q + 3'd1;
  assign obs_data = rf[obs_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      alu_opsel <= '0;
      rd_q      <= '0;
      wr_h_q    <= 1'b0;
    end else if (accept) begin
      op_a      <= rf[cmd_ra];
      op_b      <= rf[cmd_rb];
      alu_opsel <= cmd_opsel;
      rd_q      <= cmd_rd;
      wr_h_q    <= cmd_wr_h;
    end
  end

  // Writeback assignments follow the load so they win on an index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (ld_en) begin
        rf[ld_addr] <= ld_data;
      end
      if (wb) begin
        rf[rd_q] <= alu_result_l;
        if (wr_h_q) begin
          rf[rd_h] <= alu_result_h;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
      done  <= 1'b0;
    end else begin
      done <= wb;
      if (wb) begin
        flags <= {ovf_flag, cf_flag, zero_flag_h, zero_flag_l};
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small behavioural ALU attached to its operand outputs.
module tb_alu_issue;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_MUL = 4'h2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_opsel = '0;
  logic [2:0] cmd_ra = '0, cmd_rb = '0, cmd_rd = '0;
  logic       cmd_wr_h = 1'b0;
  logic       ld_en = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [2:0] obs_addr = '0;
  logic [7:0] obs_data, op_a, op_b;
  logic [3:0] alu_opsel;
  logic [7:0] alu_result_l, alu_result_h;
  logic       ovf_flag, cf_flag, zero_flag_l, zero_flag_h;
  logic [3:0] flags;
  logic       done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue #(.REG_WIDTH(8), .OPSEL_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opsel(cmd_opsel),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_wr_h(cmd_wr_h),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .obs_addr(obs_addr), .obs_data(obs_data),
    .op_a(op_a), .op_b(op_b), .alu_opsel(alu_opsel),
    .alu_result_l(alu_result_l), .alu_result_h(alu_result_h),
    .ovf_flag(ovf_flag), .cf_flag(cf_flag),
    .zero_flag_l(zero_flag_l), .zero_flag_h(zero_flag_h),
    .flags(flags), .done(done)
  );

  // Stand-in ALU: ADD gives carry/signed overflow, MUL gives a 16-bit product
  logic [8:0]  sum9;
  logic [15:0] prod;
  always_comb begin
    sum9         = {1'b0, op_a} + {1'b0, op_b};
    prod         = 16'(op_a) * 16'(op_b);
    alu_result_l = '0;
    alu_result_h = '0;
    cf_flag      = 1'b0;
    ovf_flag     = 1'b0;
    case (alu_opsel)
      OP_ADD: begin
        alu_result_l = sum9[7:0];
        cf_flag      = sum9[8];
        ovf_flag     = (op_a[7] == op_b[7]) && (sum9[7] != op_a[7]);
      end
      OP_MUL: begin
        alu_result_l = prod[7:0];
        alu_result_h = prod[15:8];
      end
      default: ;
    endcase
    zero_flag_l = (alu_result_l == 8'h00);
    zero_flag_h = (alu_result_h == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] v);
    obs_addr = a;
    #1;
    v = obs_data;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd_reg(a, v);
    chk(tag, 32'(v), 32'(exp));
  endtask

  // ld_phase: 0 none, 1 load during EXEC, 2 load during WB
  task automatic issue(input string tag, input logic [3:0] op, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] rd, input logic wrh,
                       input logic [7:0] exp_a, input logic [7:0] exp_b,
                       input int ld_phase, input logic [2:0] la, input logic [7:0] ldv);
    cmd_opsel = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_wr_h = wrh;
    cmd_valid = 1'b1;
    chk({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_ready_exec"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_op_a"}, 32'(op_a), 32'(exp_a));
    chk({tag, "_op_b"}, 32'(op_b), 32'(exp_b));
    chk({tag, "_opsel"}, 32'(alu_opsel), 32'(op));
    if (ld_phase == 1) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ldv;
    end
    tick();
    ld_en = 1'b0;
    chk({tag, "_ready_wb"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    if (ld_phase == 2) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ldv;
    end
    tick();
    ld_en = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int acc;
    int first_acc;
    int second_acc;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_opsel", 32'(alu_opsel), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset asserted while a command is in EXEC
    load(3'd0, 8'hAA);
    chk_reg("abort_r0_loaded", 3'd0, 8'hAA);
    cmd_opsel = OP_ADD; cmd_ra = 3'd0; cmd_rb = 3'd0; cmd_rd = 3'd1; cmd_wr_h = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("abort_op_a", 32'(op_a), 32'hAA);
    rst_n = 1'b0;
    #2;
    chk_reg("abort_r0", 3'd0, 8'h00);
    chk_reg("abort_r1", 3'd1, 8'h00);
    chk("abort_op_a_rst", 32'(op_a), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_done2", 32'(done), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk_reg("abort_r1_after", 3'd1, 8'h00);

    // ADD 5 + 3
    load(3'd1, 8'h05);
    load(3'd2, 8'h03);
    issue("add", OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 8'h05, 8'h03, 0, 3'd0, 8'h00);
    chk_reg("add_r3", 3'd3, 8'h08);
    chk("add_flags", 32'(flags), 32'b0010);

    // ADD FF + 01 -> carry out, zero low
    load(3'd1, 8'hFF);
    load(3'd2, 8'h01);
    issue("carry", OP_ADD, 3'd1, 3'd2, 3'd4, 1'b0, 8'hFF, 8'h01, 0, 3'd0, 8'h00);
    chk_reg("carry_r4", 3'd4, 8'h00);
    chk("carry_flags", 32'(flags), 32'b0111);

    // MUL 0x10*0x10 with high write wrapping rd=7 onto r0
    load(3'd1, 8'h10);
    load(3'd2, 8'h10);
    issue("mul", OP_MUL, 3'd1, 3'd2, 3'd7, 1'b1, 8'h10, 8'h10, 0, 3'd0, 8'h00);
    chk_reg("mul_r7", 3'd7, 8'h00);
    chk_reg("mul_r0", 3'd0, 8'h01);
    chk("mul_flags", 32'(flags), 32'b0001);

    load(3'd6, 8'h55);
    chk("flags_hold_ld", 32'(flags), 32'b0001);
    chk_reg("ld_r6", 3'd6, 8'h55);

    // Load to a source during EXEC must not disturb the in-flight operands
    issue("exec_ld", OP_ADD, 3'd1, 3'd2, 3'd6, 1'b0, 8'h10, 8'h10, 1, 3'd1, 8'h77);
    chk_reg("exec_ld_r6", 3'd6, 8'h20);
    chk_reg("exec_ld_r1", 3'd1, 8'h77);
    chk("exec_ld_flags", 32'(flags), 32'b0010);

    // Collision in WB: writeback wins (0x77+0x10 also sets signed overflow)
    issue("coll", OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, 8'h77, 8'h10, 2, 3'd3, 8'hEE);
    chk_reg("coll_r3", 3'd3, 8'h87);
    chk("coll_flags", 32'(flags), 32'b1010);
    issue("side", OP_ADD, 3'd2, 3'd2, 3'd3, 1'b0, 8'h10, 8'h10, 2, 3'd5, 8'h5A);
    chk_reg("side_r3", 3'd3, 8'h20);
    chk_reg("side_r5", 3'd5, 8'h5A);

    // Handshake: valid held 6 cycles, two commands, second depends on the first
    acc = 0; first_acc = -1; second_acc = -1;
    cmd_opsel = OP_ADD; cmd_ra = 3'd2; cmd_rb = 3'd2; cmd_rd = 3'd1; cmd_wr_h = 1'b0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (cmd_ready) begin
        acc++;
        if (first_acc < 0) first_acc = c;
        else if (second_acc < 0) second_acc = c;
      end
      if (c == 1 || c == 2 || c == 4 || c == 5)
        chk("hs_ready_low", 32'(cmd_ready), 32'd0);
      tick();
      if (c == 0) begin
        cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_rd = 3'd0;
      end
    end
    cmd_valid = 1'b0;
    chk("hs_acc_count", 32'(acc), 32'd2);
    chk("hs_acc_gap", 32'(second_acc - first_acc), 32'd3);
    chk("hs_done", 32'(done), 32'd1);
    chk_reg("hs_r1", 3'd1, 8'h20);
    chk_reg("hs_r0", 3'd0, 8'h30);
    tick();
    chk("hs_idle_ready", 32'(cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
